// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, run/done handshake, branch redirect and load stalls.
// Latency: one cycle per instruction, LOAD_LAT+1 cycles per load; ProgCtr/Done registered.
// Backpressure: loads stall the PC for LOAD_LAT cycles; Start is ignored while busy.
module prog_sequencer #(
  parameter int PCW      = 10,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PCW-1:0]  StartAddr,
  input  logic            Branch,
  input  logic            Taken,
  input  logic [PCW-1:0]  Target,
  input  logic            MemtoReg,
  input  logic            Halt,
  output logic [PCW-1:0]  ProgCtr,
  output logic            InstrValid,
  output logic            Busy,
  output logic            Done,
  output logic [CNTW-1:0] CycleCnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  // A zero latency makes loads behave like any other instruction.
  localparam logic [3:0] LAT4    = 4'(LOAD_LAT);
  localparam bit         HAS_LAT = (LOAD_LAT != 0);

  state_t        state;
  state_t        state_nxt;
  logic [PCW-1:0] pc_nxt;
  logic          done_nxt;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_nxt;
  logic          clr_cnt;
  logic          cnt_sat;

  assign Busy    = (state == S_RUN) || (state == S_LOAD_WAIT);
  assign cnt_sat = &CycleCnt;

  // Next-state, next-PC and commit qualifier; Halt outranks load, load outranks branch.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = ProgCtr;
    done_nxt   = Done;
    wait_nxt   = wait_cnt;
    clr_cnt    = 1'b0;
    InstrValid = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_nxt = S_RUN;
          pc_nxt    = StartAddr;
          done_nxt  = 1'b0;
          clr_cnt   = 1'b1;
        end
      end
      S_RUN: begin
        InstrValid = 1'b1;
        if (Halt) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (MemtoReg && HAS_LAT) begin
          // The load commits only at the end of its wait, not on issue.
          state_nxt  = S_LOAD_WAIT;
          wait_nxt   = LAT4;
          InstrValid = 1'b0;
        end else if (Branch && Taken) begin
          pc_nxt = Target;
        end else begin
          pc_nxt = ProgCtr + PCW'(1);
        end
      end
      S_LOAD_WAIT: begin
        wait_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          InstrValid = 1'b1;
          state_nxt  = S_RUN;
          pc_nxt     = ProgCtr + PCW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC, done flag, wait counter and saturating busy-cycle counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      ProgCtr  <= '0;
      Done     <= 1'b0;
      wait_cnt <= 4'd0;
      CycleCnt <= '0;
    end else begin
      state    <= state_nxt;
      ProgCtr  <= pc_nxt;
      Done     <= done_nxt;
      wait_cnt <= wait_nxt;
      if (clr_cnt) begin
        CycleCnt <= '0;
      end else if (Busy && !cnt_sat) begin
        CycleCnt <= CycleCnt + CNTW'(1);
      end
    end
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Multi-cycle program sequencer for the single-issue processor. It owns the program counter and run/done handshake, steps through instruction memory, and applies taken branches from the control decoder's `Branch` output and the ALU condition. It stalls on loads for a configurable memory latency and produces the `InstrValid` qualifier that gates register-file and data-memory writes. It sits between the top-level `Start`/`Done` handshake, instruction ROM addressing and the control decoder.

## Interface
- `PCW`, 10: program counter width; PC wraps modulo 2^PCW.
- `LOAD_LAT`, 1: extra stall cycles per load, legal 0..15.
- `CNTW`, 16: cycle counter width.

- `Clk`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  begin program; sampled in IDLE or DONE only.
- `StartAddr`  in  PCW  first PC of the program.
- `Branch`  in  1  decoder: current instruction is a conditional branch.
- `Taken`  in  1  ALU condition for the current branch.
- `Target`  in  PCW  absolute branch target.
- `MemtoReg`  in  1  decoder: current instruction is a load.
- `Halt`  in  1  decoder: current instruction ends the program.
- `ProgCtr`  out  PCW  instruction ROM address, registered.
- `InstrValid`  out  1  current instruction commits this cycle; gates RegWrite/MemWrite.
- `Busy`  out  1  high in RUN or LOAD_WAIT.
- `Done`  out  1  registered, sticky program-complete flag.
- `CycleCnt`  out  CNTW  cycles spent in RUN plus LOAD_WAIT for the current or last program, saturating.

## Operation
- States: IDLE, RUN, LOAD_WAIT, DONE. 4-bit `WaitCnt` internal.
- Reset: state IDLE, `ProgCtr`=0, `Done`=0, `CycleCnt`=0, `WaitCnt`=0. `InstrValid` and `Busy` are 0 as a consequence. Reset mid-run aborts at the next edge with no partial commit.
- IDLE/DONE with `Start`=1: go to RUN, `ProgCtr`<=`StartAddr`, `Done`<=0, `CycleCnt`<=0. Without `Start`, all registers hold.
- RUN, evaluated each cycle in strict priority order:
  - `Halt`: go to DONE, `Done`<=1, `ProgCtr` holds.
  - `MemtoReg` and `LOAD_LAT`>0: go to LOAD_WAIT, `WaitCnt`<=`LOAD_LAT`, `ProgCtr` holds.
  - `Branch`&`Taken`: `ProgCtr`<=`Target`.
  - Otherwise `ProgCtr`<=`ProgCtr`+1, wrapping 2^PCW-1 to 0.
- LOAD_WAIT: `WaitCnt` decrements. When `WaitCnt`==1, go to RUN and set `ProgCtr`<=`ProgCtr`+1. `Branch`, `Halt` and `Start` are ignored.
- `InstrValid` is combinational from state and inputs:
  - RUN: 1, except 0 when a load is entering LOAD_WAIT.
  - LOAD_WAIT: 1 only when `WaitCnt`==1, so the load writes back exactly once.
  - IDLE/DONE: 0.
  - A `Halt` cycle has `InstrValid`=1.
- `Busy` = state is RUN or LOAD_WAIT.
- `CycleCnt` increments in every RUN and LOAD_WAIT cycle and saturates at 2^CNTW-1. It holds in IDLE and DONE.
- `Start` in RUN or LOAD_WAIT is ignored. `Start` coinciding with `Halt` in RUN is ignored, and the block enters DONE.

## Timing
- `Start` sampled at edge k: RUN and `ProgCtr`=`StartAddr` from cycle k+1; first instruction commits in cycle k+1.
- Non-load instruction: 1 cycle. Taken branch: `Target` visible the following cycle, no bubble.
- Load: `LOAD_LAT`+1 cycles; `ProgCtr` is constant throughout; commit occurs in the last cycle.
- `Halt` in cycle n: `Done`=1 and `Busy`=0 from cycle n+1. `CycleCnt` includes cycle n.
- `Done` stays high until an accepted `Start` or `Reset`.

## Test plan
- Reset then idle 5 cycles: `ProgCtr`=0, `Done`=0, `Busy`=0, `InstrValid`=0, `CycleCnt`=0 throughout.
- `StartAddr`=5, `Start` pulse, 3 plain instructions then `Halt` at PC 8: `ProgCtr` 5,6,7,8 on consecutive cycles; `Done`=1 the next cycle; `CycleCnt`=4.
- Branch at PC 3 with `Taken`=1 and `Target`=40: next `ProgCtr`=40. Repeat with `Taken`=0: next `ProgCtr`=4.
- `LOAD_LAT`=2, load at PC 10: `ProgCtr`=10 for 3 cycles with `InstrValid` 0,0,1, then 11. With `LOAD_LAT`=0, load at PC 10: 1 cycle, `InstrValid`=1, then `ProgCtr`=11.
- `PCW`=4, `StartAddr`=14, no branches: `ProgCtr` 14,15,0,1. `Start` pulsed mid-run has no effect.
- `Reset` during LOAD_WAIT: next cycle all outputs at reset values. A subsequent `Start` from DONE restarts, clears `Done` and `CycleCnt`, and loads `StartAddr`.
